// File: rtl/decode_stage.sv
// Single-entry RV32 decode stage: classifies an instruction word and extracts fields/immediate.
// Optional macro DECODE_SYSTEM_EN decodes opcode 1110011 as SYS instead of ILLEGAL.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_type,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [XLEN-1:0]  out_imm,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int T_R    = 0;
  localparam int T_I    = 1;
  localparam int T_LD   = 2;
  localparam int T_JALR = 3;
  localparam int T_S    = 4;
  localparam int T_SB   = 5;
  localparam int T_AUI  = 6;
  localparam int T_LUI  = 7;
  localparam int T_JAL  = 8;
  localparam int T_SYS  = 9;
  localparam int T_ILL  = 10;

  logic [10:0]     typ_d;
  logic [31:0]     imm32;
  logic [XLEN-1:0] imm_d;
  logic            accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready && !flush;

  // Opcode to one-hot class; low bits other than 11 never match the map.
  always_comb begin
    typ_d = '0;
    unique case (in_instr[6:0])
      7'b0110011: typ_d[T_R]    = 1'b1;
      7'b0010011: typ_d[T_I]    = 1'b1;
      7'b0000011: typ_d[T_LD]   = 1'b1;
      7'b1100111: typ_d[T_JALR] = 1'b1;
      7'b0100011: typ_d[T_S]    = 1'b1;
      7'b1100011: typ_d[T_SB]   = 1'b1;
      7'b0010111: typ_d[T_AUI]  = 1'b1;
      7'b0110111: typ_d[T_LUI]  = 1'b1;
      7'b1101111: typ_d[T_JAL]  = 1'b1;
`ifdef DECODE_SYSTEM_EN
      7'b1110011: typ_d[T_SYS]  = 1'b1;
`endif
      default:    typ_d[T_ILL]  = 1'b1;
    endcase
  end

  // Immediate assembled as 32 bits, then sign-extended to XLEN from instr[31].
  always_comb begin
    imm32 = '0;
    unique case (1'b1)
      typ_d[T_I], typ_d[T_LD], typ_d[T_JALR], typ_d[T_SYS]:
        imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      typ_d[T_S]:
        imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      typ_d[T_SB]:
        imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                 in_instr[30:25], in_instr[11:8], 1'b0};
      typ_d[T_AUI], typ_d[T_LUI]:
        imm32 = {in_instr[31:12], 12'b0};
      typ_d[T_JAL]:
        imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                 in_instr[20], in_instr[30:21], 1'b0};
      default:
        imm32 = '0;
    endcase
    imm_d        = {XLEN{imm32[31]}};
    imm_d[31:0]  = imm32;
  end

  // Pipeline register: reset, then flush, then capture, then drain.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_type    <= '0;
      out_rd      <= '0;
      out_rs1     <= '0;
      out_rs2     <= '0;
      out_funct3  <= '0;
      out_funct7  <= '0;
      out_imm     <= '0;
      illegal_cnt <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_type   <= typ_d;
      out_rd     <= in_instr[11:7];
      out_rs1    <= in_instr[19:15];
      out_rs2    <= in_instr[24:20];
      out_funct3 <= in_instr[14:12];
      out_funct7 <= in_instr[31:25];
      out_imm    <= imm_d;
      if (typ_d[T_ILL] && (illegal_cnt != '1))
        illegal_cnt <= illegal_cnt + CNT_W'(1);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: default instance plus an XLEN=64, CNT_W=2 instance.
// Build with or without DECODE_SYSTEM_EN; expectations follow the same macro.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [31:0] in_instr;

  logic        a_in_ready, a_out_valid;
  logic [10:0] a_type;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [2:0]  a_f3;
  logic [6:0]  a_f7;
  logic [31:0] a_imm;
  logic [15:0] a_cnt;

  logic        b_in_ready, b_out_valid;
  logic [10:0] b_type;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [2:0]  b_f3;
  logic [6:0]  b_f7;
  logic [63:0] b_imm;
  logic [1:0]  b_cnt;

  decode_stage u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(a_in_ready), .in_instr(in_instr),
    .out_valid(a_out_valid), .out_ready(out_ready),
    .out_type(a_type), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_funct3(a_f3), .out_funct7(a_f7), .out_imm(a_imm),
    .illegal_cnt(a_cnt)
  );

  decode_stage #(.XLEN(64), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_instr(in_instr),
    .out_valid(b_out_valid), .out_ready(out_ready),
    .out_type(b_type), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_funct3(b_f3), .out_funct7(b_f7), .out_imm(b_imm),
    .illegal_cnt(b_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] t;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [63:0] imm;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   c1    = 0;
  int   c2    = 0;
  logic was_rst;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] i);
    exp_t e;
    e.rd  = i[11:7];
    e.rs1 = i[19:15];
    e.rs2 = i[24:20];
    e.f3  = i[14:12];
    e.f7  = i[31:25];
    e.imm = '0;
    case (i[6:0])
      7'h33: e.t = 11'h001;
      7'h13: e.t = 11'h002;
      7'h03: e.t = 11'h004;
      7'h67: e.t = 11'h008;
      7'h23: e.t = 11'h010;
      7'h63: e.t = 11'h020;
      7'h17: e.t = 11'h040;
      7'h37: e.t = 11'h080;
      7'h6F: e.t = 11'h100;
`ifdef DECODE_SYSTEM_EN
      7'h73: e.t = 11'h200;
`endif
      default: e.t = 11'h400;
    endcase
    case (e.t)
      11'h002, 11'h004, 11'h008, 11'h200:
        e.imm = {{52{i[31]}}, i[31:20]};
      11'h010:
        e.imm = {{52{i[31]}}, i[31:25], i[11:7]};
      11'h020:
        e.imm = {{51{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      11'h040, 11'h080:
        e.imm = {{32{i[31]}}, i[31:12], 12'b0};
      11'h100:
        e.imm = {{43{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default:
        e.imm = '0;
    endcase
    return e;
  endfunction

  task automatic cyc(input logic v, input logic [31:0] ins,
                     input logic rdy, input logic fl, input logic r);
    logic exp_ready, acc;
    exp_t e;
    in_valid  = v;
    in_instr  = ins;
    out_ready = rdy;
    flush     = fl;
    rst       = r;
    @(negedge clk);
    exp_ready = (q.size() == 0) || rdy;
    if (!r) begin
      check("in_ready", 64'(a_in_ready), 64'(exp_ready));
      check("in_ready2", 64'(b_in_ready), 64'(exp_ready));
    end
    acc = v && exp_ready && !fl && !r;
    e   = model(ins);
    @(posedge clk);
    was_rst = r;
    if (r) begin
      q.delete();
      c1 = 0;
      c2 = 0;
    end else if (fl) begin
      q.delete();
    end else begin
      if (q.size() != 0 && rdy) void'(q.pop_front());
      if (acc) begin
        q.push_back(e);
        if (e.t[10]) begin
          if (c1 < 65535) c1++;
          if (c2 < 3) c2++;
        end
      end
    end
    #1;
    check("out_valid", 64'(a_out_valid), 64'(q.size() != 0));
    check("out_valid2", 64'(b_out_valid), 64'(q.size() != 0));
    check("cnt", 64'(a_cnt), 64'(c1));
    check("cnt2", 64'(b_cnt), 64'(c2));
    if (q.size() != 0) begin
      check("type", 64'(a_type), 64'(q[0].t));
      check("rd", 64'(a_rd), 64'(q[0].rd));
      check("rs1", 64'(a_rs1), 64'(q[0].rs1));
      check("rs2", 64'(a_rs2), 64'(q[0].rs2));
      check("f3", 64'(a_f3), 64'(q[0].f3));
      check("f7", 64'(a_f7), 64'(q[0].f7));
      check("imm", 64'(a_imm), 64'(q[0].imm[31:0]));
      check("type2", 64'(b_type), 64'(q[0].t));
      check("imm2", b_imm, q[0].imm);
    end else if (was_rst) begin
      check("rst_type", 64'(a_type), 64'd0);
      check("rst_imm", 64'(a_imm), 64'd0);
      check("rst_rd", 64'(a_rd), 64'd0);
      check("rst_imm2", b_imm, 64'd0);
    end
  endtask

  logic [31:0] pool [12] = '{
    32'h00A00093, 32'hFE000EE3, 32'hFFFFFFFF, 32'h00000000,
    32'h00000073, 32'h002081B3, 32'hFFC12083, 32'h000080E7,
    32'hFE112E23, 32'h800002B7, 32'hFFFFF517, 32'h8000006F
  };

  int saved;

  initial begin
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 1, 0, 0);

    cyc(1, 32'h00A00093, 1, 0, 0);
    check("r032_type", 64'(a_type), 64'h002);
    check("r032_rd", 64'(a_rd), 64'd1);
    check("r032_imm", 64'(a_imm), 64'd10);
    cyc(0, 0, 1, 0, 0);

    cyc(1, 32'hFE000EE3, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 32'h00A00093, 0, 0, 0);
      check("r033_type", 64'(a_type), 64'h020);
      check("r033_imm", 64'(a_imm), 64'hFFFFFFFC);
      check("r033_rdy", 64'(a_in_ready), 64'd0);
    end
    cyc(0, 0, 1, 0, 0);

    cyc(1, 32'hFFFFFFFF, 1, 0, 0);
    cyc(1, 32'h00000000, 1, 0, 0);
    check("r034_type", 64'(a_type), 64'h400);
    check("r034_cnt", 64'(a_cnt), 64'd2);

    saved = c1;
    cyc(1, 32'h00000073, 1, 0, 0);
`ifdef DECODE_SYSTEM_EN
    check("r035_type", 64'(a_type), 64'h200);
    check("r035_cnt", 64'(a_cnt), 64'(saved));
`else
    check("r035_type", 64'(a_type), 64'h400);
    check("r035_cnt", 64'(a_cnt), 64'(saved + 1));
`endif

    cyc(1, 32'h00A00093, 0, 0, 0);
    saved = c1;
    cyc(1, 32'hFFFFFFFF, 0, 1, 0);
    check("r036_valid", 64'(a_out_valid), 64'd0);
    check("r036_cnt", 64'(a_cnt), 64'(saved));

    for (int k = 0; k < 5; k++) cyc(1, 32'hFFFFFFFF, 1, 0, 0);
    check("r037_sat", 64'(b_cnt), 64'd3);
    cyc(1, 32'h00000000, 1, 0, 0);
    check("r037_hold", 64'(b_cnt), 64'd3);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 32'hFFFFFFFF, 0, 0, 1);
    check("r037_rst_cnt", 64'(b_cnt), 64'd0);
    check("r037_rst_vld", 64'(b_out_valid), 64'd0);

    for (int k = 0; k < 300; k++) begin
      logic [31:0] w;
      w = ($urandom_range(0, 3) == 0) ? $urandom() :
          pool[$urandom_range(0, 11)];
      cyc($urandom_range(0, 3) != 0, w, $urandom_range(0, 2) != 0,
          $urandom_range(0, 15) == 0, $urandom_range(0, 63) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 Parameter: XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter: CNT_W, default 16, width of the illegal-instruction counter.
REQ-003 Clock and reset: one clock; reset is synchronous and active-high.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: rst  input  1  synchronous active-high reset.
REQ-006 Port: flush  input  1  discard the held result and block capture this cycle.
REQ-007 Port: in_valid  input  1  in_instr is valid.
REQ-008 Port: in_ready  output  1  stage accepts in_instr this cycle.
REQ-009 Port: in_instr  input  32  raw instruction word.
REQ-010 Port: out_valid  output  1  decoded result is held and valid.
REQ-011 Port: out_ready  input  1  consumer takes the result this cycle.
REQ-012 Port: out_type  output  11  one-hot class, bit order 0..10: R, I, I_load, I_jalr, S, SB, U_auipc, U_lui, UJ_jal, SYS, ILLEGAL.
REQ-013 Port: out_rd / out_rs1 / out_rs2  output  5 each  fields instr[11:7] / [19:15] / [24:20].
REQ-014 Port: out_funct3 / out_funct7  output  3 / 7  fields instr[14:12] / [31:25].
REQ-015 Port: out_imm  output  XLEN  sign-extended immediate.
REQ-016 Port: illegal_cnt  output  CNT_W  saturating count of accepted illegal instructions.

Function
REQ-017 Opcode map: 0110011 R; 0010011 I; 0000011 I_load; 1100111 I_jalr; 0100011 S; 1100011 SB; 0010111 U_auipc; 0110111 U_lui; 1101111 UJ_jal.
REQ-018 Any other opcode, or instr[1:0] != 2'b11, selects ILLEGAL; out_type has exactly one bit set whenever out_valid=1.
REQ-019 Immediates: I/I_load/I_jalr/SYS use instr[31:20]; S uses {[31:25],[11:7]}; SB uses {[31],[7],[30:25],[11:8],0}; U uses {[31:12],12'b0}; UJ uses {[31],[19:12],[20],[30:21],0}; R and ILLEGAL give 0.
REQ-020 All immediates sign-extend from instr[31] to XLEN, including U when XLEN=64.
REQ-021 in_ready = !out_valid || out_ready (combinational, single-entry pipeline register).
REQ-022 Accept = in_valid && in_ready && !flush; on accept, all out_* load the decode of in_instr at the next edge, and out_valid=1.
REQ-023 Latency: exactly 1 cycle from accept to out_valid=1; throughput 1 instruction/cycle while out_ready=1.
REQ-024 out_valid=1 && out_ready=0 && !flush: all out_* hold stable.
REQ-025 out_valid=1 && out_ready=1 && no accept: out_valid clears next cycle.
REQ-026 flush=1: out_valid=0 next cycle regardless of in_valid/out_ready; flush has priority over capture.
REQ-027 illegal_cnt increments by 1 on each accept of an ILLEGAL instruction; it holds at 2^CNT_W-1 once saturated; flushed-away inputs are not counted.

Reset
REQ-028 rst=1 at an edge: out_valid=0, illegal_cnt=0, out_type/fields/imm=0; rst overrides flush and accept.
REQ-029 Reset while out_valid=1 with out_ready=0 discards the held result; no transfer occurs in the reset cycle.

Configuration
REQ-030 Macro DECODE_SYSTEM_EN defined: opcode 1110011 decodes to SYS (bit 9) with I-type immediate.
REQ-031 Macro DECODE_SYSTEM_EN undefined: opcode 1110011 decodes to ILLEGAL and counts; out_type bit 9 is constant 0; port list is unchanged.

Verification
REQ-032 Accept 0x00A00093 (addi x1,x0,10), out_ready=1 -> next cycle out_valid=1, out_type=11'h002, rd=1, out_imm=10.
REQ-033 Accept 0xFE000EE3 (SB, offset -4) with out_ready=0 for 3 cycles -> out_type=11'h020, out_imm=-4 (all ones except [1:0]=00), outputs stable, in_ready=0.
REQ-034 Accept 0xFFFFFFFF then 0x00000000 back-to-back -> both ILLEGAL (11'h400), illegal_cnt=2.
REQ-035 Accept 0x00000073 -> SYS (11'h200) with DECODE_SYSTEM_EN, ILLEGAL with illegal_cnt+1 without.
REQ-036 in_valid=1, flush=1 with out_valid=1 -> out_valid=0 next cycle, nothing captured, illegal_cnt unchanged.
REQ-037 CNT_W=2, accept 5 illegal instructions -> illegal_cnt reaches 3 and stays 3; then rst=1 -> illegal_cnt=0, out_valid=0.
